// File: rtl/hiscore_pkg.sv
// Shared definitions for the high-score upload path: config record layout,
// reader FSM states and the stored region format.
package hiscore_pkg;

    localparam int REC_BYTES = 8;
    localparam int REC_SHIFT = $clog2(REC_BYTES);

    localparam logic [REC_SHIFT-1:0] FLD_START_B0 = 3'd0;
    localparam logic [REC_SHIFT-1:0] FLD_START_B1 = 3'd1;
    localparam logic [REC_SHIFT-1:0] FLD_START_B2 = 3'd2;
    localparam logic [REC_SHIFT-1:0] FLD_START_B3 = 3'd3;
    localparam logic [REC_SHIFT-1:0] FLD_LEN_HI   = 3'd4;
    localparam logic [REC_SHIFT-1:0] FLD_LEN_LO   = 3'd5;
    localparam logic [REC_SHIFT-1:0] FLD_LAST     = 3'd7;

    localparam int REGION_ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_READY   = 3'd2,
        ST_FETCH   = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    typedef struct packed {
        logic [REGION_ADDR_W-1:0] start;
        logic [15:0]              len;
    } region_t;

endpackage

// File: rtl/hiscore_cfg_table.sv
// Region table: parses 8-byte config records and serves the first non-empty
// region at or after the requested entry index.
module hiscore_cfg_table
    import hiscore_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              wr,
    input  logic [24:0]       addr,
    input  logic [7:0]        data,
    input  logic [3:0]        entry,
    output logic [3:0]        eff_entry,
    output logic [ADDR_W-1:0] start,
    output logic [15:0]       len,
    output logic [3:0]        cfg_count,
    output logic              cfg_ovf
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int REC_W = 25 - REC_SHIFT;
    localparam logic [REC_W-1:0] ENTRIES_REC = REC_W'(ENTRIES);

    region_t             table_r [ENTRIES];
    logic [31:0]         start_acc_r;
    logic [15:0]         len_acc_r;
    logic [3:0]          count_r;
    logic                ovf_r;
    logic [REC_W-1:0]    rec_s;
    logic [REC_SHIFT-1:0] byte_s;
    logic                rec_ok_s;
    logic [3:0]          rec_cnt_s;
    logic [3:0]          eff_s;
    logic                found_s;

    assign rec_s     = addr[24:REC_SHIFT];
    assign byte_s    = addr[REC_SHIFT-1:0];
    assign rec_ok_s  = (rec_s < ENTRIES_REC);
    assign rec_cnt_s = 4'(rec_s) + 4'd1;

    // Record assembly, commit on the last byte, count/overflow tracking.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= '0;
            end
            start_acc_r <= 32'd0;
            len_acc_r   <= 16'd0;
            count_r     <= 4'd0;
            ovf_r       <= 1'b0;
        end else begin
            if (wr) begin
                case (byte_s)
                    FLD_START_B0: start_acc_r[31:24] <= data;
                    FLD_START_B1: start_acc_r[23:16] <= data;
                    FLD_START_B2: start_acc_r[15:8]  <= data;
                    FLD_START_B3: start_acc_r[7:0]   <= data;
                    FLD_LEN_HI:   len_acc_r[15:8]    <= data;
                    FLD_LEN_LO:   len_acc_r[7:0]     <= data;
                    FLD_LAST: begin
                        if (rec_ok_s) begin
                            table_r[rec_s[IDX_W-1:0]] <= '{
                                start: REGION_ADDR_W'(start_acc_r[ADDR_W-1:0]),
                                len:   len_acc_r
                            };
                            if (rec_cnt_s > count_r) begin
                                count_r <= rec_cnt_s;
                            end
                        end else begin
                            ovf_r <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (clear) begin
                count_r <= 4'd0;
                ovf_r   <= 1'b0;
            end
        end
    end

    // Zero-length regions are skipped here so the reader never addresses them.
    always_comb begin
        eff_s   = count_r;
        found_s = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!found_s && (4'(i) >= entry) && (4'(i) < count_r) &&
                (table_r[i].len != 16'd0)) begin
                eff_s   = 4'(i);
                found_s = 1'b1;
            end else begin
                eff_s = eff_s;
            end
        end
    end

    // Region fields of the selected entry; zero when the table is exhausted.
    always_comb begin
        if (eff_s < count_r) begin
            start = ADDR_W'(table_r[eff_s[IDX_W-1:0]].start);
            len   = table_r[eff_s[IDX_W-1:0]].len;
        end else begin
            start = '0;
            len   = 16'd0;
        end
    end

    assign eff_entry = eff_s;
    assign cfg_count = count_r;
    assign cfg_ovf   = ovf_r;

endmodule

// File: rtl/hiscore_upload.sv
// High-score upload reader: pauses the core, then streams game RAM bytes of the
// configured regions onto ioctl_din with ioctl_wait handshaking.
module hiscore_upload
    import hiscore_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int ENTRIES   = 8,
    parameter int CFG_INDEX = 3,
    parameter int HS_INDEX  = 4,
    parameter int RAM_LAT   = 2,
    parameter int SETTLE    = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_rd,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [7:0]        ram_data,
    output logic              pause,
    output logic [3:0]        cfg_count,
    output logic              cfg_ovf
);

    localparam logic [8:0] SETTLE_LAST = 9'(SETTLE);
    localparam logic [3:0] LAT_LAST    = 4'(RAM_LAT);

    state_t            state_r, state_s;
    logic [8:0]        settle_r, settle_s;
    logic [3:0]        lat_r, lat_s;
    logic [3:0]        entry_r, entry_s;
    logic [15:0]       offset_r, offset_s;
    logic [7:0]        din_r, din_s;
    logic              wait_r, wait_s;
    logic              pause_r, pause_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              upload_q_r, download_q_r;
    logic              upload_rise_s, upload_fall_s;
    logic              cfg_sel_s, cfg_wr_s, cfg_clear_s;
    logic [3:0]        eff_entry_s;
    logic [ADDR_W-1:0] tbl_start_s;
    logic [15:0]       tbl_len_s;

    // Config traffic is only accepted while no upload is in progress.
    assign cfg_sel_s     = ioctl_download & (ioctl_index == 8'(CFG_INDEX)) &
                           ~ioctl_upload & (state_r == ST_IDLE);
    assign cfg_wr_s      = cfg_sel_s & ioctl_wr;
    assign cfg_clear_s   = cfg_sel_s & ~download_q_r;
    assign upload_rise_s = ioctl_upload & ~upload_q_r & (ioctl_index == 8'(HS_INDEX));
    assign upload_fall_s = ~ioctl_upload & upload_q_r;

    hiscore_cfg_table #(
        .ADDR_W  (ADDR_W),
        .ENTRIES (ENTRIES)
    ) u_table (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .clear     (cfg_clear_s),
        .wr        (cfg_wr_s),
        .addr      (ioctl_addr),
        .data      (ioctl_dout),
        .entry     (entry_r),
        .eff_entry (eff_entry_s),
        .start     (tbl_start_s),
        .len       (tbl_len_s),
        .cfg_count (cfg_count),
        .cfg_ovf   (cfg_ovf)
    );

    // State, sequencing counters and all registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            settle_r     <= 9'd0;
            lat_r        <= 4'd0;
            entry_r      <= 4'd0;
            offset_r     <= 16'd0;
            din_r        <= 8'd0;
            wait_r       <= 1'b0;
            pause_r      <= 1'b0;
            addr_r       <= '0;
            upload_q_r   <= 1'b0;
            download_q_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_r     <= settle_s;
            lat_r        <= lat_s;
            entry_r      <= entry_s;
            offset_r     <= offset_s;
            din_r        <= din_s;
            wait_r       <= wait_s;
            pause_r      <= pause_s;
            addr_r       <= addr_s;
            upload_q_r   <= ioctl_upload;
            download_q_r <= ioctl_download;
        end
    end

    // Next-state and next-output logic of the reader.
    always_comb begin
        state_s  = state_r;
        settle_s = settle_r;
        lat_s    = lat_r;
        entry_s  = entry_r;
        offset_s = offset_r;
        din_s    = din_r;
        wait_s   = wait_r;
        pause_s  = pause_r;
        addr_s   = addr_r;
        if (upload_fall_s) begin
            state_s = ST_IDLE;
            pause_s = 1'b0;
            wait_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    din_s = 8'd0;
                    if (upload_rise_s) begin
                        pause_s  = 1'b1;
                        wait_s   = 1'b1;
                        settle_s = 9'd0;
                        entry_s  = 4'd0;
                        offset_s = 16'd0;
                        state_s  = ST_SETTLE;
                    end else begin
                        pause_s = 1'b0;
                        wait_s  = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_r == SETTLE_LAST) begin
                        wait_s  = 1'b0;
                        state_s = ST_READY;
                    end else begin
                        settle_s = settle_r + 9'd1;
                    end
                end
                ST_READY: begin
                    if (ioctl_rd) begin
                        wait_s = 1'b1;
                        if (eff_entry_s < cfg_count) begin
                            addr_s  = tbl_start_s + ADDR_W'(offset_r);
                            entry_s = eff_entry_s;
                            lat_s   = 4'd0;
                            state_s = ST_FETCH;
                        end else begin
                            din_s   = 8'd0;
                            state_s = ST_PRESENT;
                        end
                    end else begin
                        state_s = ST_READY;
                    end
                end
                ST_FETCH: begin
                    if (lat_r == LAT_LAST) begin
                        din_s   = ram_data;
                        state_s = ST_PRESENT;
                        if ((offset_r + 16'd1) == tbl_len_s) begin
                            entry_s  = entry_r + 4'd1;
                            offset_s = 16'd0;
                        end else begin
                            offset_s = offset_r + 16'd1;
                        end
                    end else begin
                        lat_s = lat_r + 4'd1;
                    end
                end
                ST_PRESENT: begin
                    wait_s  = 1'b0;
                    state_s = ST_READY;
                end
                default: begin
                    state_s = ST_IDLE;
                    pause_s = 1'b0;
                    wait_s  = 1'b0;
                end
            endcase
        end
    end

    assign ioctl_din   = din_r;
    assign ioctl_wait  = wait_r;
    assign ram_address = addr_r;
    assign pause       = pause_r;

endmodule
